// File: rtl/digital_sound_input.sv
// Serial audio receiver: synchronises bck/lrck/sd into clk, realigns on lrck
// transitions and deserialises 16-bit left/right words into a registered pair.
module digital_sound_input #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  logic        bck,
  input  logic        sd,
  input  logic        lrck,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        valid,
  output logic        error,
  input  logic        error_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] bck_sync_r;
  logic [SYNC_STAGES-1:0] sd_sync_r;
  logic [SYNC_STAGES-1:0] lrck_sync_r;
  logic                   bck_s;
  logic                   sd_s;
  logic                   lrck_s;

  logic                   bck_d_r;
  logic                   rise_r;
  logic                   sd_cap_r;
  logic                   lrck_cap_r;
  logic                   prev_lrck_r;

  state_t                 state_r;
  logic [5:0]             count_r;
  logic [15:0]            shift_r;
  logic [15:0]            left_hold_r;
  logic [15:0]            right_word_r;
  logic                   slot_left_r;
  logic                   left_held_r;
  logic                   commit_r;

  logic                   slot_start_s;
  logic                   err_set_s;
  logic [15:0]            shifted_s;

  assign bck_s  = bck_sync_r[SYNC_STAGES-1];
  assign sd_s   = sd_sync_r[SYNC_STAGES-1];
  assign lrck_s = lrck_sync_r[SYNC_STAGES-1];

  // Multi-stage synchronisers for the three asynchronous pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      bck_sync_r  <= '0;
      sd_sync_r   <= '0;
      lrck_sync_r <= '0;
    end else begin
      bck_sync_r  <= {bck_sync_r[SYNC_STAGES-2:0], bck};
      sd_sync_r   <= {sd_sync_r[SYNC_STAGES-2:0], sd};
      lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], lrck};
    end
  end

  // bck rise detection; sd and lrck are captured alongside so they align with the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bck_d_r    <= 1'b0;
      rise_r     <= 1'b0;
      sd_cap_r   <= 1'b0;
      lrck_cap_r <= 1'b0;
    end else begin
      bck_d_r    <= bck_s;
      rise_r     <= bck_s & ~bck_d_r;
      sd_cap_r   <= sd_s;
      lrck_cap_r <= lrck_s;
    end
  end

  // Slot-start and framing-error decode for the current rise event.
  always_comb begin
    slot_start_s = 1'b0;
    err_set_s    = 1'b0;
    shifted_s    = {shift_r[14:0], sd_cap_r};
    if (rise_r) begin
      slot_start_s = (lrck_cap_r != prev_lrck_r);
    end else begin
      slot_start_s = 1'b0;
    end
    if (rise_r && enabled) begin
      case (state_r)
        SHIFT:   err_set_s = slot_start_s;
        HOLD:    err_set_s = !slot_start_s && (count_r == 6'd32);
        default: err_set_s = 1'b0;
      endcase
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Receive FSM, frame commit and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      count_r      <= 6'd0;
      shift_r      <= 16'd0;
      left_hold_r  <= 16'd0;
      right_word_r <= 16'd0;
      slot_left_r  <= 1'b0;
      left_held_r  <= 1'b0;
      commit_r     <= 1'b0;
      prev_lrck_r  <= 1'b0;
      left         <= 16'd0;
      right        <= 16'd0;
      valid        <= 1'b0;
      error        <= 1'b0;
    end else begin
      valid    <= 1'b0;
      commit_r <= 1'b0;
      if (commit_r) begin
        left  <= left_hold_r;
        right <= right_word_r;
        valid <= 1'b1;
      end

      if (err_set_s) begin
        error <= 1'b1;
      end else if (error_clr) begin
        error <= 1'b0;
      end

      if (rise_r) begin
        prev_lrck_r <= lrck_cap_r;
      end

      if (!enabled) begin
        state_r     <= IDLE;
        count_r     <= 6'd0;
        left_held_r <= 1'b0;
      end else if (rise_r) begin
        case (state_r)
          IDLE: begin
            if (slot_start_s) begin
              shift_r     <= {15'd0, sd_cap_r};
              count_r     <= 6'd1;
              slot_left_r <= lrck_cap_r;
              state_r     <= SHIFT;
            end
          end
          SHIFT: begin
            if (slot_start_s) begin
              // Short slot: drop the partial word and restart on the new slot.
              if (slot_left_r) begin
                left_held_r <= 1'b0;
              end
              shift_r     <= {15'd0, sd_cap_r};
              count_r     <= 6'd1;
              slot_left_r <= lrck_cap_r;
            end else begin
              shift_r <= shifted_s;
              count_r <= count_r + 6'd1;
              if (count_r == 6'd15) begin
                state_r <= HOLD;
                if (slot_left_r) begin
                  left_hold_r <= shifted_s;
                  left_held_r <= 1'b1;
                end else if (left_held_r) begin
                  right_word_r <= shifted_s;
                  commit_r     <= 1'b1;
                  left_held_r  <= 1'b0;
                end
              end
            end
          end
          HOLD: begin
            if (slot_start_s) begin
              shift_r     <= {15'd0, sd_cap_r};
              count_r     <= 6'd1;
              slot_left_r <= lrck_cap_r;
              state_r     <= SHIFT;
            end else if (count_r == 6'd32) begin
              state_r     <= IDLE;
              count_r     <= 6'd0;
              left_held_r <= 1'b0;
            end else begin
              count_r <= count_r + 6'd1;
            end
          end
          default: begin
            state_r     <= IDLE;
            count_r     <= 6'd0;
            left_held_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digital_sound_input.sv
// Scoreboard bench for digital_sound_input: a slot-level model predicts frames,
// a monitor pops and compares on every valid pulse.
module tb_digital_sound_input;

  logic        clk = 1'b0;
  logic        rst;
  logic        enabled;
  logic        bck;
  logic        sd;
  logic        lrck;
  logic        error_clr;
  logic [15:0] left;
  logic [15:0] right;
  logic        valid;
  logic        error;

  digital_sound_input #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enabled(enabled), .bck(bck), .sd(sd), .lrck(lrck),
    .left(left), .right(right), .valid(valid), .error(error), .error_clr(error_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat_mark = 0;
  int last_valid_cyc = 0;
  int n_valid = 0;
  int half = 12;
  logic [31:0] exp_q[$];

  // slot-level reference model state
  logic        m_held = 1'b0;
  logic        m_synced = 1'b0;
  logic        m_err = 1'b0;
  logic        m_prev = 1'b0;
  logic [15:0] m_left = 16'd0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got %h/%h expected no valid pulse", left, right);
      end else begin
        e = exp_q.pop_front();
        check("frame", {32'd0, left, right}, {32'd0, e});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic lr, input logic b, input logic mark);
    bck = 1'b0; lrck = lr; sd = b;
    tick(half);
    bck = 1'b1;
    if (mark) lat_mark = cyc + 1;
    tick(half);
  endtask

  task automatic drive_slot(input logic lr, input int nbits, input logic [31:0] data, input logic mark);
    for (int i = 0; i < nbits; i++) begin
      send_bit(lr, (i < 32) ? data[31 - i] : 1'b0, mark && (i == 15));
    end
  endtask

  task automatic model_slot(input logic lr, input int nbits, input logic [15:0] w);
    if (lr != m_prev && enabled) m_synced = 1'b1;
    m_prev = lr;
    if (m_synced) begin
      if (nbits < 16) begin
        m_err = 1'b1;
        if (lr) m_held = 1'b0;
      end else if (nbits > 32) begin
        m_err = 1'b1;
        m_held = 1'b0;
      end else if (lr) begin
        m_held = 1'b1;
        m_left = w;
      end else begin
        if (m_held) exp_q.push_back({m_left, w});
        m_held = 1'b0;
      end
    end
  endtask

  task automatic frame_slot(input logic lr, input int nbits, input logic [15:0] w, input logic [15:0] pad);
    model_slot(lr, nbits, w);
    drive_slot(lr, nbits, {w, pad}, 1'b0);
  endtask

  task automatic clear_error();
    error_clr = 1'b1;
    tick(1);
    error_clr = 1'b0;
    m_err = 1'b0;
    tick(1);
  endtask

  initial begin
    int seg_start;
    logic [15:0] wl, wr;
    int nl, nr;
    rst = 1'b1; enabled = 1'b1; bck = 1'b0; sd = 1'b0; lrck = 1'b0; error_clr = 1'b0;
    @(negedge clk);
    tick(3);
    rst = 1'b0;
    check("reset_state", {30'd0, left, right, valid, error}, 64'd0);

    // basic frame plus latency of the 16th right bit
    frame_slot(1'b1, 16, 16'hA55A, 16'h0000);
    model_slot(1'b0, 16, 16'h1234);
    drive_slot(1'b0, 16, {16'h1234, 16'h0000}, 1'b1);
    tick(20);
    check("basic_valid_count", n_valid, 1);
    check("basic_latency", last_valid_cyc - lat_mark, 4);
    check("basic_hold", {32'd0, left, right}, {32'd0, 16'hA55A, 16'h1234});
    check("basic_error", error, 0);

    // wide 24-bit slots with padding
    frame_slot(1'b1, 24, 16'h8001, 16'hFF00);
    frame_slot(1'b0, 24, 16'h7FFE, 16'h0000);
    tick(20);
    check("wide_out", {32'd0, left, right}, {32'd0, 16'h8001, 16'h7FFE});
    check("wide_error", error, m_err);

    // short left slot, orphan right, then a good frame
    frame_slot(1'b1, 12, 16'hFFFF, 16'h0000);
    frame_slot(1'b0, 16, 16'hBEEF, 16'h0000);
    frame_slot(1'b1, 16, 16'h1111, 16'h0000);
    frame_slot(1'b0, 16, 16'h2222, 16'h0000);
    tick(20);
    check("short_error", error, 1);
    check("short_next_frame", {32'd0, left, right}, {32'd0, 16'h1111, 16'h2222});
    clear_error();
    check("error_clr", error, 0);

    // error_clr held across the edge where a new short slot is detected: set wins
    frame_slot(1'b1, 9, 16'h0000, 16'h0000);
    model_slot(1'b0, 16, 16'h5A5A);
    bck = 1'b0; lrck = 1'b0; sd = 1'b0;
    tick(half);
    bck = 1'b1; error_clr = 1'b1;
    tick(4);
    error_clr = 1'b0;
    tick(1);
    check("set_beats_clr", error, 1);
    tick(half - 5);
    drive_slot(1'b0, 15, {16'h5A5A, 16'h0000} << 1, 1'b0);
    clear_error();

    // over-length slot saturates the counter
    frame_slot(1'b1, 34, 16'hCAFE, 16'hFFFF);
    frame_slot(1'b0, 16, 16'h0BAD, 16'h0000);
    frame_slot(1'b1, 16, 16'h3333, 16'h0000);
    frame_slot(1'b0, 16, 16'h4444, 16'h0000);
    tick(20);
    check("overlen_error", error, m_err);
    check("overlen_next_frame", {32'd0, left, right}, {32'd0, 16'h3333, 16'h4444});

    // reset during the 10th right bit
    frame_slot(1'b1, 16, 16'h6789, 16'h0000);
    drive_slot(1'b0, 9, {16'h9876, 16'h0000}, 1'b0);
    bck = 1'b0; lrck = 1'b0; sd = 1'b1;
    tick(half);
    bck = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_held = 1'b0; m_synced = 1'b0; m_err = 1'b0; m_prev = 1'b0;
    check("reset_mid_frame", {30'd0, left, right, valid, error}, 64'd0);
    tick(half - 5);
    seg_start = n_valid;
    drive_slot(1'b0, 6, {16'h9876, 16'h0000} << 10, 1'b0);
    tick(20);
    check("reset_no_valid", n_valid - seg_start, 0);
    frame_slot(1'b1, 16, 16'h0F0F, 16'h0000);
    frame_slot(1'b0, 16, 16'hF0F0, 16'h0000);
    tick(20);
    check("reset_resync", {32'd0, left, right}, {32'd0, 16'h0F0F, 16'hF0F0});

    // enable raised during the 9th bit of a left slot
    enabled = 1'b0; m_synced = 1'b0; m_held = 1'b0;
    tick(10);
    seg_start = n_valid;
    m_prev = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) enabled = 1'b1;
      send_bit(1'b1, 1'b1, 1'b0);
    end
    frame_slot(1'b0, 16, 16'hDEAD, 16'h0000);
    for (int f = 0; f < 3; f++) begin
      frame_slot(1'b1, 16, 16'h1000 + 16'(f), 16'h0000);
      frame_slot(1'b0, 16, 16'h2000 + 16'(f), 16'h0000);
    end
    tick(20);
    check("enable_valid_count", n_valid - seg_start, 3);

    // randomised frames with varying bck rate and slot widths
    for (int f = 0; f < 25; f++) begin
      half = $urandom_range(2, 8);
      wl = 16'($urandom);
      wr = 16'($urandom);
      nl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 32);
      nr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 32);
      frame_slot(1'b1, nl, wl, 16'($urandom));
      frame_slot(1'b0, nr, wr, 16'($urandom));
    end
    frame_slot(1'b1, 16, 16'h7777, 16'h0000);
    frame_slot(1'b0, 16, 16'h8888, 16'h0000);
    tick(20);
    check("random_error", error, m_err);
    check("random_last_frame", {32'd0, left, right}, {32'd0, 16'h7777, 16'h8888});
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
